// File: rtl/mem_store_sequencer.sv
// mem_store_sequencer
//   Store-side controller between the MEM stage and the data memory write
//   port. Store requests are buffered in a small FIFO, turned into
//   byte-lane-encoded word-aligned write beats, and presented with a
//   valid/ready handshake. Stores that straddle a word boundary are split
//   into two consecutive aligned beats.
//
// Lane convention: byte offset k <-> mem_wdata[31-8k:24-8k] <-> mem_be[k].
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  store request present
//   req_ready  FIFO can accept a request (not full)
//   req_addr   byte address
//   req_data   right-justified store value
//   req_size   0 = word, 1 = half, 2 = byte, 3 = illegal
//   mem_valid  write beat presented
//   mem_ready  memory accepts the beat
//   mem_addr   word-aligned beat address
//   mem_wdata  lane-placed write data
//   mem_be     byte enables
//   err        one-cycle pulse when an illegal-size request is dropped
//   busy       FIFO non-empty or FSM not idle
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | nothing in flight; pops the FIFO head when one is present
// ST_BEAT0 | first (or only) beat of the working request on the port
// ST_BEAT1 | second beat of a boundary-crossing store on the port
// ST_DROP  | illegal-size request discarded; err high this cycle

module mem_store_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              err,
  output logic              busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Request FIFO storage (data only; pointers/count live with the FSM)
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [31:0]       fifo_data_q [DEPTH];
  logic [1:0]        fifo_size_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign req_ready  = !fifo_full;
  assign push       = req_valid && !fifo_full;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= req_addr;
      fifo_data_q[wr_ptr_q] <= req_data;
      fifo_size_q[wr_ptr_q] <= req_size;
    end
  end

  // ---------------------------------------------------------------------
  // Lane placement of the FIFO head
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] head_addr;
  logic [31:0]       head_data;
  logic [1:0]        head_size;
  logic [1:0]        head_off;
  logic              head_illegal;
  logic [31:0]       lj_data;
  logic [3:0]        lj_be;
  logic [63:0]       placed_data;
  logic [7:0]        placed_be;
  logic [ADDR_W-1:0] head_b0_addr;
  logic [ADDR_W-1:0] head_b1_addr;

  always_comb begin
    head_addr    = fifo_addr_q[rd_ptr_q];
    head_data    = fifo_data_q[rd_ptr_q];
    head_size    = fifo_size_q[rd_ptr_q];
    head_off     = head_addr[1:0];
    head_illegal = (head_size == 2'd3);

    // Left-justify the store bytes so store byte i sits in lane i.
    case (head_size)
      2'd0: begin
        lj_data = head_data;
        lj_be   = 4'b1111;
      end
      2'd1: begin
        lj_data = {head_data[15:0], 16'h0000};
        lj_be   = 4'b0011;
      end
      2'd2: begin
        lj_data = {head_data[7:0], 24'h000000};
        lj_be   = 4'b0001;
      end
      default: begin
        lj_data = 32'h0000_0000;
        lj_be   = 4'b0000;
      end
    endcase

    // Eight virtual lanes spanning two words: the upper half is beat 0,
    // the lower half beat 1. Moving by the byte offset handles the split.
    placed_data  = {lj_data, 32'h0000_0000} >> {head_off, 3'b000};
    placed_be    = {4'b0000, lj_be} << head_off;

    head_b0_addr = {head_addr[ADDR_W-1:2], 2'b00};
    head_b1_addr = head_b0_addr + ADDR_W'(4);
  end

  // ---------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------
  state_t            state_q, state_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q,    mem_be_d;
  logic              err_q,       err_d;
  // Second beat of the working request, held until beat 0 is accepted.
  logic [ADDR_W-1:0] b1_addr_q,   b1_addr_d;
  logic [31:0]       b1_wdata_q,  b1_wdata_d;
  logic [3:0]        b1_be_q,     b1_be_d;

  logic finish;

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    err_d       = 1'b0;
    b1_addr_d   = b1_addr_q;
    b1_wdata_d  = b1_wdata_q;
    b1_be_d     = b1_be_q;
    finish      = 1'b0;
    pop         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pop = !fifo_empty;
      end
      ST_BEAT0: begin
        if (mem_ready) begin
          // A non-zero second-beat enable is exactly the o+n > 4 case.
          if (b1_be_q != 4'b0000) begin
            state_d     = ST_BEAT1;
            mem_addr_d  = b1_addr_q;
            mem_wdata_d = b1_wdata_q;
            mem_be_d    = b1_be_q;
          end else begin
            finish = 1'b1;
          end
        end
      end
      ST_BEAT1: begin
        finish = mem_ready;
      end
      ST_DROP: begin
        finish = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (finish) begin
      if (!fifo_empty) begin
        pop = 1'b1;
      end else begin
        state_d     = ST_IDLE;
        mem_valid_d = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = 32'h0000_0000;
        mem_be_d    = 4'b0000;
      end
    end

    if (pop) begin
      if (head_illegal) begin
        state_d     = ST_DROP;
        err_d       = 1'b1;
        mem_valid_d = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = 32'h0000_0000;
        mem_be_d    = 4'b0000;
        b1_be_d     = 4'b0000;
      end else begin
        state_d     = ST_BEAT0;
        mem_valid_d = 1'b1;
        mem_addr_d  = head_b0_addr;
        mem_wdata_d = placed_data[63:32];
        mem_be_d    = placed_be[3:0];
        b1_addr_d   = head_b1_addr;
        b1_wdata_d  = placed_data[31:0];
        b1_be_d     = placed_be[7:4];
      end
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0000_0000;
      mem_be_q    <= 4'b0000;
      err_q       <= 1'b0;
      b1_addr_q   <= '0;
      b1_wdata_q  <= 32'h0000_0000;
      b1_be_q     <= 4'b0000;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      err_q       <= err_d;
      b1_addr_q   <= b1_addr_d;
      b1_wdata_q  <= b1_wdata_d;
      b1_be_q     <= b1_be_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign err       = err_q;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_store_sequencer.sv
module tb_mem_store_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        err;
  logic        busy;

  int tests;
  int fails;

  mem_store_sequencer #(.ADDR_W(32), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .err       (err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_data  = 32'h0;
    req_size  = 2'd0;
  endtask

  // Present one request for a single edge (accepted there when ready).
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    drive(a, d, s);
    tick();
    idle_req();
  endtask

  task automatic beat(input string tag, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd);
    chk({tag, "_valid"}, {31'b0, mem_valid}, 32'd1);
    chk({tag, "_addr"},  mem_addr, a);
    chk({tag, "_be"},    {28'b0, mem_be}, {28'b0, be});
    chk({tag, "_wdata"}, mem_wdata, wd);
  endtask

  task automatic quiet(input string tag);
    chk({tag, "_valid"}, {31'b0, mem_valid}, 32'd0);
    chk({tag, "_busy"},  {31'b0, busy}, 32'd0);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    idle_req();
    tick();
    tick();

    // Reset state
    chk("rst_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_addr",  mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_be",    {28'b0, mem_be}, 32'h0);
    chk("rst_err",   {31'b0, err}, 32'd0);
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Aligned word
    mem_ready = 1'b1;
    send(32'h100, 32'h11223344, 2'd0);
    chk("sw_lat_valid", {31'b0, mem_valid}, 32'd0);
    chk("sw_lat_busy",  {31'b0, busy}, 32'd1);
    tick();
    beat("sw", 32'h100, 4'b1111, 32'h11223344);
    tick();
    quiet("sw_done");

    // Byte at offset 3
    send(32'h203, 32'h000000AB, 2'd2);
    tick();
    beat("sb", 32'h200, 4'b1000, 32'h000000AB);
    tick();
    quiet("sb_done");

    // Half at offset 2
    send(32'h302, 32'h0000BEEF, 2'd1);
    tick();
    beat("sh", 32'h300, 4'b1100, 32'h0000BEEF);
    tick();
    quiet("sh_done");

    // Misaligned word: two consecutive beats
    send(32'h401, 32'hAABBCCDD, 2'd0);
    tick();
    beat("msw_b0", 32'h400, 4'b1110, 32'h00AABBCC);
    tick();
    beat("msw_b1", 32'h404, 4'b0001, 32'hDD000000);
    tick();
    quiet("msw_done");

    // Misaligned half at offset 3
    send(32'h503, 32'h00001234, 2'd1);
    tick();
    beat("msh_b0", 32'h500, 4'b1000, 32'h00000012);
    tick();
    beat("msh_b1", 32'h504, 4'b0001, 32'h34000000);
    tick();
    quiet("msh_done");

    // Address wrap on the second beat
    send(32'hFFFFFFFD, 32'h01020304, 2'd0);
    tick();
    beat("wrap_b0", 32'hFFFFFFFC, 4'b1110, 32'h00010203);
    tick();
    beat("wrap_b1", 32'h00000000, 4'b0001, 32'h04000000);
    tick();
    quiet("wrap_done");

    // Backpressure: capacity is three, fourth request refused
    mem_ready = 1'b0;
    drive(32'h700, 32'hA0A1A2A3, 2'd0);
    chk("bp_rdy_a", {31'b0, req_ready}, 32'd1);
    tick();
    drive(32'h704, 32'hB0B1B2B3, 2'd0);
    chk("bp_rdy_b", {31'b0, req_ready}, 32'd1);
    tick();
    beat("bp_hold0", 32'h700, 4'b1111, 32'hA0A1A2A3);
    drive(32'h709, 32'h000000CC, 2'd2);
    chk("bp_rdy_c", {31'b0, req_ready}, 32'd1);
    tick();
    drive(32'h710, 32'hD0D1D2D3, 2'd0);
    chk("bp_rdy_d", {31'b0, req_ready}, 32'd0);
    beat("bp_hold1", 32'h700, 4'b1111, 32'hA0A1A2A3);
    tick();
    chk("bp_rdy_d2", {31'b0, req_ready}, 32'd0);
    beat("bp_hold2", 32'h700, 4'b1111, 32'hA0A1A2A3);
    tick();
    beat("bp_hold3", 32'h700, 4'b1111, 32'hA0A1A2A3);
    idle_req();
    mem_ready = 1'b1;
    tick();
    beat("bp_b", 32'h704, 4'b1111, 32'hB0B1B2B3);
    chk("bp_rdy_free", {31'b0, req_ready}, 32'd1);
    tick();
    beat("bp_c", 32'h708, 4'b0010, 32'h00CC0000);
    tick();
    quiet("bp_done");
    tick();
    quiet("bp_no_d");

    // Illegal size between two words
    drive(32'h800, 32'h55667788, 2'd0);
    tick();
    drive(32'h600, 32'hDEADBEEF, 2'd3);
    tick();
    beat("ill_x", 32'h800, 4'b1111, 32'h55667788);
    chk("ill_err0", {31'b0, err}, 32'd0);
    drive(32'h900, 32'h99AABBCC, 2'd0);
    tick();
    idle_req();
    chk("ill_err1",   {31'b0, err}, 32'd1);
    chk("ill_nobeat", {31'b0, mem_valid}, 32'd0);
    tick();
    chk("ill_err2", {31'b0, err}, 32'd0);
    beat("ill_z", 32'h900, 4'b1111, 32'h99AABBCC);
    tick();
    quiet("ill_done");
    chk("ill_err3", {31'b0, err}, 32'd0);

    // Asynchronous reset during the second beat of a split store
    send(32'hA01, 32'h11223344, 2'd0);
    tick();
    beat("rs_b0", 32'hA00, 4'b1110, 32'h00112233);
    tick();
    beat("rs_b1", 32'hA04, 4'b0001, 32'h44000000);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rs_valid", {31'b0, mem_valid}, 32'd0);
    chk("rs_busy",  {31'b0, busy}, 32'd0);
    chk("rs_addr",  mem_addr, 32'h0);
    chk("rs_be",    {28'b0, mem_be}, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      quiet("rs_after");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
